// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller and its datapath:
// opcode/funct constants, FSM state codes, datapath select encodings, the
// decoded instruction class and the control-strobe bundle.
package multicycle_ctrl_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned SEL_W   = 2;

    // Primary opcodes (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    // R-type function codes (instr[5:0])
    localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
    localparam logic [OP_W-1:0] FN_JR   = 6'b001000;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // NPC source
    localparam logic [SEL_W-1:0] NPC_PC4 = 2'b00;
    localparam logic [SEL_W-1:0] NPC_BEQ = 2'b01;
    localparam logic [SEL_W-1:0] NPC_JAL = 2'b10;
    localparam logic [SEL_W-1:0] NPC_JR  = 2'b11;

    // ALU operation
    localparam logic [SEL_W-1:0] ALU_ADD = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB = 2'b01;
    localparam logic [SEL_W-1:0] ALU_OR  = 2'b10;

    // Immediate extension
    localparam logic [SEL_W-1:0] EXT_ZERO = 2'b00;
    localparam logic [SEL_W-1:0] EXT_SIGN = 2'b01;
    localparam logic [SEL_W-1:0] EXT_HIGH = 2'b10;

    // MUX1: GRF write address
    localparam logic [SEL_W-1:0] WA_RT = 2'b00;
    localparam logic [SEL_W-1:0] WA_RD = 2'b01;
    localparam logic [SEL_W-1:0] WA_RA = 2'b10;

    // MUX2: ALU second operand
    localparam logic B_RT  = 1'b0;
    localparam logic B_IMM = 1'b1;

    // MUX3: GRF write data
    localparam logic [SEL_W-1:0] WD_ALU = 2'b00;
    localparam logic [SEL_W-1:0] WD_DM  = 2'b01;
    localparam logic [SEL_W-1:0] WD_PC4 = 2'b10;

    // One-hot instruction class; nop covers every undecoded word
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic jal;
        logic nop;
    } instr_cls_t;

    // Datapath control strobes for one cycle
    typedef struct packed {
        logic             irwe;
        logic             pcwe;
        logic [SEL_W-1:0] npc_op;
        logic [SEL_W-1:0] mux1;
        logic             mux2;
        logic [SEL_W-1:0] mux3;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] ext_op;
        logic             grfwe;
        logic             dmwe;
        logic             dmre;
    } ctrl_t;

    function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] i);
        return i[31:26];
    endfunction

    function automatic logic [OP_W-1:0] instr_fn(input logic [INSTR_W-1:0] i);
        return i[5:0];
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decoder.sv
// Combinational instruction decoder: maps the latched IR word to a one-hot
// instruction class. Only opcode and funct fields participate.
//   instr  in  32  IR contents
//   cls    out     one-hot class (exactly one bit set)
module multicycle_ctrl_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output instr_cls_t         cls
);

    logic [OP_W-1:0] op;
    logic [OP_W-1:0] fn;
    logic            unused_fields;

    assign op = instr_op(instr);
    assign fn = instr_fn(instr);
    // Register/immediate fields are consumed by the datapath, not the decoder
    assign unused_fields = ^instr[25:6];

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU: cls.addu = 1'b1;
                    FN_SUBU: cls.subu = 1'b1;
                    FN_JR:   cls.jr   = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: ;
        endcase
        // Anything not recognised above (including 0x00000000) is a NOP
        cls.nop = ~(cls.addu | cls.subu | cls.jr | cls.ori | cls.lw |
                    cls.sw | cls.beq | cls.lui | cls.jal);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS datapath. Sequences
// FETCH/DECODE/EXEC/MEM/WB one phase per clock, drives datapath strobes
// combinationally from (state, instruction class), waits on DM ready and
// counts retired instructions.
//   clk, reset          clock; synchronous active-high reset
//   instr, zero         IR contents; ALU equality flag
//   dm_ready            DM access complete this cycle
//   IRWE, PCWE, NPCOp   IR load, PC write, next-PC source
//   MUX1, MUX2, MUX3    GRF write addr, ALU operand B, GRF write data
//   ALUOp, EXTOp        ALU function, immediate extension
//   GRFWE, DMWE, DMRE   register write, DM write, DM read
//   state               current FSM state code
//   retired             instructions completed since reset
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                zero,
    input  logic                dm_ready,
    output logic                IRWE,
    output logic                PCWE,
    output logic [SEL_W-1:0]    NPCOp,
    output logic [SEL_W-1:0]    MUX1,
    output logic                MUX2,
    output logic [SEL_W-1:0]    MUX3,
    output logic [SEL_W-1:0]    ALUOp,
    output logic [SEL_W-1:0]    EXTOp,
    output logic                GRFWE,
    output logic                DMWE,
    output logic                DMRE,
    output logic [STATE_W-1:0]  state,
    output logic [CNT_W-1:0]    retired
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] retired_q;
    instr_cls_t       cls;
    ctrl_t            ctl;
    logic             retire;
    logic             unused_zero;

    // zero only steers the NPC mux in the datapath; beq always writes PC
    assign unused_zero = zero;

    multicycle_ctrl_decoder u_decoder (
        .instr (instr),
        .cls   (cls)
    );

    // State and retired-count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Next-state and control strobes; everything held low during reset
    always_comb begin
        ctl     = '0;
        state_d = ST_FETCH;
        retire  = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    ctl.irwe = 1'b1;
                    state_d  = ST_DECODE;
                end

                ST_DECODE: begin
                    if (cls.jal) begin
                        state_d = ST_WB;
                    end else if (cls.nop) begin
                        ctl.pcwe   = 1'b1;
                        ctl.npc_op = NPC_PC4;
                        retire     = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (cls.addu || cls.subu) begin
                        ctl.alu_op = cls.subu ? ALU_SUB : ALU_ADD;
                        ctl.mux2   = B_RT;
                        state_d    = ST_WB;
                    end else if (cls.ori || cls.lui) begin
                        ctl.alu_op = ALU_OR;
                        ctl.ext_op = cls.lui ? EXT_HIGH : EXT_ZERO;
                        ctl.mux2   = B_IMM;
                        state_d    = ST_WB;
                    end else if (cls.lw || cls.sw) begin
                        ctl.alu_op = ALU_ADD;
                        ctl.ext_op = EXT_SIGN;
                        ctl.mux2   = B_IMM;
                        state_d    = ST_MEM;
                    end else if (cls.beq) begin
                        // NPC resolves the zero test; PC is written either way
                        ctl.alu_op = ALU_SUB;
                        ctl.mux2   = B_RT;
                        ctl.pcwe   = 1'b1;
                        ctl.npc_op = NPC_BEQ;
                        retire     = 1'b1;
                        state_d    = ST_FETCH;
                    end else if (cls.jr) begin
                        ctl.pcwe   = 1'b1;
                        ctl.npc_op = NPC_JR;
                        retire     = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end

                ST_MEM: begin
                    // Address path held for the whole access; strobes idempotent
                    ctl.alu_op = ALU_ADD;
                    ctl.ext_op = EXT_SIGN;
                    ctl.mux2   = B_IMM;
                    ctl.dmre   = cls.lw;
                    ctl.dmwe   = cls.sw;
                    if (!dm_ready) begin
                        state_d = ST_MEM;
                    end else if (cls.lw) begin
                        state_d = ST_WB;
                    end else begin
                        ctl.pcwe   = 1'b1;
                        ctl.npc_op = NPC_PC4;
                        retire     = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end

                ST_WB: begin
                    ctl.grfwe = 1'b1;
                    ctl.pcwe  = 1'b1;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                    if (cls.addu || cls.subu) begin
                        ctl.mux1 = WA_RD;
                        ctl.mux3 = WD_ALU;
                    end else if (cls.lw) begin
                        ctl.mux1 = WA_RT;
                        ctl.mux3 = WD_DM;
                    end else if (cls.jal) begin
                        ctl.mux1   = WA_RA;
                        ctl.mux3   = WD_PC4;
                        ctl.npc_op = NPC_JAL;
                    end else begin
                        ctl.mux1 = WA_RT;
                        ctl.mux3 = WD_ALU;
                    end
                end

                default: state_d = ST_FETCH;
            endcase
        end
    end

    assign IRWE    = ctl.irwe;
    assign PCWE    = ctl.pcwe;
    assign NPCOp   = ctl.npc_op;
    assign MUX1    = ctl.mux1;
    assign MUX2    = ctl.mux2;
    assign MUX3    = ctl.mux3;
    assign ALUOp   = ctl.alu_op;
    assign EXTOp   = ctl.ext_op;
    assign GRFWE   = ctl.grfwe;
    assign DMWE    = ctl.dmwe;
    assign DMRE    = ctl.dmre;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle pushes the
// hand-computed expected control vector; a monitor pops and compares it
// against the DUT on the falling edge.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        dm_ready = 1'b0;
    logic        IRWE, PCWE, MUX2, GRFWE, DMWE, DMRE;
    logic [1:0]  NPCOp, MUX1, MUX3, ALUOp, EXTOp;
    logic [2:0]  state;
    logic [31:0] retired;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .zero     (zero),
        .dm_ready (dm_ready),
        .IRWE     (IRWE),
        .PCWE     (PCWE),
        .NPCOp    (NPCOp),
        .MUX1     (MUX1),
        .MUX2     (MUX2),
        .MUX3     (MUX3),
        .ALUOp    (ALUOp),
        .EXTOp    (EXTOp),
        .GRFWE    (GRFWE),
        .DMWE     (DMWE),
        .DMRE     (DMRE),
        .state    (state),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        irwe;
        logic        pcwe;
        logic [1:0]  npc;
        logic [1:0]  m1;
        logic        m2;
        logic [1:0]  m3;
        logic [1:0]  alu;
        logic [1:0]  ext;
        logic        gwe;
        logic        dwe;
        logic        dre;
        logic [31:0] ret;
    } obs_t;

    obs_t        exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] ret = 32'd0;

    localparam logic [31:0] I_ADDU = 32'h00221821;
    localparam logic [31:0] I_SUBU = 32'h00221823;
    localparam logic [31:0] I_LW   = 32'h8C040008;
    localparam logic [31:0] I_SW   = 32'hAC040008;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_JAL  = 32'h0C000010;
    localparam logic [31:0] I_ORI  = 32'h34220005;
    localparam logic [31:0] I_LUI  = 32'h3C011234;
    localparam logic [31:0] I_JR   = 32'h03E00008;
    localparam logic [31:0] I_NOP0 = 32'h00000000;
    localparam logic [31:0] I_NOPF = 32'hFC000000;

    // Expected vector: st irwe pcwe npc mux1 mux2 mux3 alu ext grfwe dmwe dmre
    function automatic obs_t mk(input int st, input int irwe, input int pcwe,
                                input int npc, input int m1, input int m2,
                                input int m3, input int alu, input int ext,
                                input int gwe, input int dwe, input int dre);
        obs_t o;
        o.st   = 3'(st);
        o.irwe = 1'(irwe);
        o.pcwe = 1'(pcwe);
        o.npc  = 2'(npc);
        o.m1   = 2'(m1);
        o.m2   = 1'(m2);
        o.m3   = 2'(m3);
        o.alu  = 2'(alu);
        o.ext  = 2'(ext);
        o.gwe  = 1'(gwe);
        o.dwe  = 1'(dwe);
        o.dre  = 1'(dre);
        o.ret  = ret;
        return o;
    endfunction

    task automatic cyc(input string nm, input logic r, input logic [31:0] ins,
                       input logic z, input logic rdy, input obs_t e);
        @(posedge clk);
        #1;
        reset    = r;
        instr    = ins;
        zero     = z;
        dm_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare one expected vector per cycle on the falling edge
    always @(negedge clk) begin : monitor
        obs_t  e;
        obs_t  a;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {state, IRWE, PCWE, NPCOp, MUX1, MUX2, MUX3, ALUOp, EXTOp,
                  GRFWE, DMWE, DMRE, retired};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got st=%0d irwe=%b pcwe=%b npc=%b m1=%b m2=%b m3=%b alu=%b ext=%b gwe=%b dwe=%b dre=%b ret=%0d, expected st=%0d irwe=%b pcwe=%b npc=%b m1=%b m2=%b m3=%b alu=%b ext=%b gwe=%b dwe=%b dre=%b ret=%0d",
                         nm, a.st, a.irwe, a.pcwe, a.npc, a.m1, a.m2, a.m3, a.alu, a.ext, a.gwe, a.dwe, a.dre, a.ret,
                         e.st, e.irwe, e.pcwe, e.npc, e.m1, e.m2, e.m3, e.alu, e.ext, e.gwe, e.dwe, e.dre, e.ret);
            end
        end
    end

    initial begin : stim
        int wait_cyc;
        // Reset: state FETCH, all strobes low
        cyc("rst0", 1'b1, I_NOP0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0,0));
        cyc("rst1", 1'b1, I_NOP0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0,0));

        // addu: F D E W
        cyc("addu_f", 1'b0, I_ADDU, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("addu_d", 1'b0, I_ADDU, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("addu_e", 1'b0, I_ADDU, 1'b0, 1'b0, mk(2,0,0,0,0,0,0,0,0,0,0,0));
        cyc("addu_w", 1'b0, I_ADDU, 1'b0, 1'b0, mk(4,0,1,0,1,0,0,0,0,1,0,0));
        ret = ret + 32'd1;

        // lw with two wait cycles: F D E M M M W
        cyc("lw_f",  1'b0, I_LW, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("lw_d",  1'b0, I_LW, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("lw_e",  1'b0, I_LW, 1'b0, 1'b0, mk(2,0,0,0,0,1,0,0,1,0,0,0));
        cyc("lw_m0", 1'b0, I_LW, 1'b0, 1'b0, mk(3,0,0,0,0,1,0,0,1,0,0,1));
        cyc("lw_m1", 1'b0, I_LW, 1'b0, 1'b0, mk(3,0,0,0,0,1,0,0,1,0,0,1));
        cyc("lw_m2", 1'b0, I_LW, 1'b0, 1'b1, mk(3,0,0,0,0,1,0,0,1,0,0,1));
        cyc("lw_w",  1'b0, I_LW, 1'b0, 1'b0, mk(4,0,1,0,0,0,1,0,0,1,0,0));
        ret = ret + 32'd1;

        // beq taken and not taken: identical strobes
        cyc("beq1_f", 1'b0, I_BEQ, 1'b1, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("beq1_d", 1'b0, I_BEQ, 1'b1, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("beq1_e", 1'b0, I_BEQ, 1'b1, 1'b0, mk(2,0,1,1,0,0,0,1,0,0,0,0));
        ret = ret + 32'd1;
        cyc("beq0_f", 1'b0, I_BEQ, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("beq0_d", 1'b0, I_BEQ, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("beq0_e", 1'b0, I_BEQ, 1'b0, 1'b0, mk(2,0,1,1,0,0,0,1,0,0,0,0));
        ret = ret + 32'd1;

        // jal: F D W
        cyc("jal_f", 1'b0, I_JAL, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("jal_d", 1'b0, I_JAL, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("jal_w", 1'b0, I_JAL, 1'b0, 1'b0, mk(4,0,1,2,2,0,2,0,0,1,0,0));
        ret = ret + 32'd1;

        // NOP class: all-zero word and unknown opcode
        cyc("nop0_f", 1'b0, I_NOP0, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("nop0_d", 1'b0, I_NOP0, 1'b0, 1'b0, mk(1,0,1,0,0,0,0,0,0,0,0,0));
        ret = ret + 32'd1;
        cyc("nopf_f", 1'b0, I_NOPF, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("nopf_d", 1'b0, I_NOPF, 1'b0, 1'b0, mk(1,0,1,0,0,0,0,0,0,0,0,0));
        ret = ret + 32'd1;

        // ori / lui / subu
        cyc("ori_f", 1'b0, I_ORI, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("ori_d", 1'b0, I_ORI, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("ori_e", 1'b0, I_ORI, 1'b0, 1'b0, mk(2,0,0,0,0,1,0,2,0,0,0,0));
        cyc("ori_w", 1'b0, I_ORI, 1'b0, 1'b0, mk(4,0,1,0,0,0,0,0,0,1,0,0));
        ret = ret + 32'd1;
        cyc("lui_f", 1'b0, I_LUI, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("lui_d", 1'b0, I_LUI, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("lui_e", 1'b0, I_LUI, 1'b0, 1'b0, mk(2,0,0,0,0,1,0,2,2,0,0,0));
        cyc("lui_w", 1'b0, I_LUI, 1'b0, 1'b0, mk(4,0,1,0,0,0,0,0,0,1,0,0));
        ret = ret + 32'd1;
        cyc("subu_f", 1'b0, I_SUBU, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("subu_d", 1'b0, I_SUBU, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("subu_e", 1'b0, I_SUBU, 1'b0, 1'b0, mk(2,0,0,0,0,0,0,1,0,0,0,0));
        cyc("subu_w", 1'b0, I_SUBU, 1'b0, 1'b0, mk(4,0,1,0,1,0,0,0,0,1,0,0));
        ret = ret + 32'd1;

        // jr: F D E
        cyc("jr_f", 1'b0, I_JR, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("jr_d", 1'b0, I_JR, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("jr_e", 1'b0, I_JR, 1'b0, 1'b0, mk(2,0,1,3,0,0,0,0,0,0,0,0));
        ret = ret + 32'd1;

        // sw with one wait cycle: F D E M M
        cyc("sw_f",  1'b0, I_SW, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("sw_d",  1'b0, I_SW, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("sw_e",  1'b0, I_SW, 1'b0, 1'b0, mk(2,0,0,0,0,1,0,0,1,0,0,0));
        cyc("sw_m0", 1'b0, I_SW, 1'b0, 1'b0, mk(3,0,0,0,0,1,0,0,1,0,1,0));
        cyc("sw_m1", 1'b0, I_SW, 1'b0, 1'b1, mk(3,0,1,0,0,1,0,0,1,0,1,0));
        ret = ret + 32'd1;

        // sw interrupted by reset in MEM: strobes drop, never retires
        cyc("swr_f",  1'b0, I_SW, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("swr_d",  1'b0, I_SW, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("swr_e",  1'b0, I_SW, 1'b0, 1'b0, mk(2,0,0,0,0,1,0,0,1,0,0,0));
        cyc("swr_m0", 1'b0, I_SW, 1'b0, 1'b0, mk(3,0,0,0,0,1,0,0,1,0,1,0));
        cyc("swr_rst", 1'b1, I_SW, 1'b0, 1'b0, mk(3,0,0,0,0,0,0,0,0,0,0,0));
        ret = 32'd0;
        cyc("post_f", 1'b0, I_ADDU, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("post_d", 1'b0, I_ADDU, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0));

        // Drain the scoreboard with a bounded wait
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
